// File: rtl/load_store_unit.sv
// Load/store unit between the MEM pipeline stage and a word-wide synchronous data memory.
// Handles byte/half/word accesses with sign/zero extension, read-modify-write sub-word stores and misalignment traps.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

    state_t                  state_reg, state_next;
    logic                    write_reg;
    logic [1:0]              size_reg;
    logic                    unsigned_reg;
    logic [1:0]              lane_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic                    err_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic [DATA_WIDTH-1:0]   mem_wdata_reg;

    logic                    misaligned;
    logic                    accept;
    logic [7:0]              byte_val;
    logic [15:0]             half_val;
    logic [DATA_WIDTH-1:0]   load_val;
    logic [DATA_WIDTH-1:0]   merged;

    assign accept = (state_reg == IDLE) && req_valid;

    always_comb begin
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned)
                        state_next = DONE;
                    else if (req_write && req_size == 2'b10)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ:    state_next = WAIT;
            WAIT:    state_next = write_reg ? WRITE : DONE;
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Load extraction: little-endian lane select, then extend.
    always_comb begin
        byte_val = 8'(mem_rdata >> {lane_reg, 3'b000});
        half_val = lane_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_reg)
            2'b00:   load_val = unsigned_reg ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
            2'b01:   load_val = unsigned_reg ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
            default: load_val = mem_rdata;
        endcase
    end

    // Store merge: each byte lane takes new data only when the access covers it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            logic lane_hit;
            assign lane_hit = (size_reg == 2'b00 && lane_reg == 2'(gi)) ||
                              (size_reg == 2'b01 && lane_reg[1] == 1'(gi / 2));
            assign merged[8*gi +: 8] = !lane_hit          ? mem_rdata[8*gi +: 8] :
                                       (size_reg == 2'b00) ? wdata_reg[7:0] :
                                                             wdata_reg[8*(gi % 2) +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            write_reg     <= 1'b0;
            size_reg      <= 2'b00;
            unsigned_reg  <= 1'b0;
            lane_reg      <= 2'b00;
            wdata_reg     <= '0;
            err_reg       <= 1'b0;
            rdata_reg     <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                write_reg     <= req_write;
                size_reg      <= req_size;
                unsigned_reg  <= req_unsigned;
                lane_reg      <= req_addr[1:0];
                wdata_reg     <= req_wdata;
                err_reg       <= misaligned;
                mem_addr_reg  <= {2'b00, req_addr[ADDR_WIDTH-1:2]};
                mem_wdata_reg <= req_wdata;
            end
            if (state_reg == WAIT) begin
                if (write_reg)
                    mem_wdata_reg <= merged;
                else
                    rdata_reg <= load_val;
            end
        end
    end

    assign busy      = req_valid && (state_reg != DONE);
    assign done      = (state_reg == DONE);
    assign err       = (state_reg == DONE) && err_reg;
    assign mem_read  = (state_reg == READ);
    assign mem_write = (state_reg == WRITE);
    assign rdata     = rdata_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read word memory behind it.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        busy, done, err, mem_write, mem_read;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:15];
    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_read)  mem_rdata <= mem[mem_addr[3:0]];
        if (mem_write) mem[mem_addr[3:0]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one access at posedge+1 and step until done; reports latency and strobes seen.
    task automatic do_op(input string name, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d, input logic drop_early,
                         output int lat, output logic saw_rd, output logic saw_wr,
                         output logic [31:0] wdat, output logic [31:0] maddr, output logic errv);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        lat = 0; saw_rd = 0; saw_wr = 0; wdat = '0; maddr = '0; errv = 0;
        #1 check({name, "_busy_t0"}, 32'(busy), 32'd1);
        while (lat < 12) begin
            @(posedge clk); #1;
            lat++;
            if (drop_early) req_valid = 1'b0;
            if (mem_read)  begin saw_rd = 1; maddr = mem_addr; end
            if (mem_write) begin saw_wr = 1; maddr = mem_addr; wdat = mem_wdata; end
            if (mem_read && mem_write) check({name, "_both_strobes"}, 32'd1, 32'd0);
            if (done) break;
        end
        if (!done) check({name, "_timeout"}, 32'(done), 32'd1);
        errv = err;
        check({name, "_busy_done"}, 32'(busy), 32'd0);
        req_valid = 1'b0;
        $display("[TB] %s addr=0x%08h lat=%0d rd=%0d wr=%0d wdata=0x%08h err=%0d rdata=0x%08h",
                 name, a, lat, saw_rd, saw_wr, wdat, errv, rdata);
        @(posedge clk); #1;
    endtask

    int          lat;
    logic        srd, swr, e;
    logic [31:0] wd, ma;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h8001_7FFF;
        mem[1] = 32'h1122_3344;
        mem[2] = 32'h0BAD_F00D;
        mem_rdata = '0;
        rst = 1'b1; req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_strobes", {30'h0, mem_read, mem_write}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // sw 0x8
        do_op("sw", 1, 2'b10, 0, 32'h8, 32'hDEADBEEF, 0, lat, srd, swr, wd, ma, e);
        check("sw_lat", lat, 2);
        check("sw_wr", {srd, swr}, 2'b01);
        check("sw_wdata", wd, 32'hDEADBEEF);
        check("sw_addr", ma, 2);
        check("sw_err", 32'(e), 0);

        do_op("lb", 0, 2'b00, 0, 32'hB, 0, 0, lat, srd, swr, wd, ma, e);
        check("lb_lat", lat, 3);
        check("lb_rd", {srd, swr}, 2'b10);
        check("lb_addr", ma, 2);
        check("lb_rdata", rdata, 32'hFFFFFFDE);

        do_op("lbu", 0, 2'b00, 1, 32'hB, 0, 0, lat, srd, swr, wd, ma, e);
        check("lbu_rdata", rdata, 32'h000000DE);

        do_op("sh", 1, 2'b01, 0, 32'hA, 32'h00001234, 0, lat, srd, swr, wd, ma, e);
        check("sh_lat", lat, 4);
        check("sh_wdata", wd, 32'h1234BEEF);
        check("sh_strobes", {srd, swr}, 2'b11);
        check("sh_keeps_rdata", rdata, 32'h000000DE);

        do_op("lh", 0, 2'b01, 0, 32'h2, 0, 0, lat, srd, swr, wd, ma, e);
        check("lh_rdata", rdata, 32'hFFFF8001);
        do_op("lhu", 0, 2'b01, 1, 32'h2, 0, 0, lat, srd, swr, wd, ma, e);
        check("lhu_rdata", rdata, 32'h00008001);

        do_op("lw_mis", 0, 2'b10, 0, 32'h6, 0, 0, lat, srd, swr, wd, ma, e);
        check("lw_mis_lat", lat, 1);
        check("lw_mis_err", 32'(e), 1);
        check("lw_mis_strobes", {srd, swr}, 0);
        check("lw_mis_rdata", rdata, 32'h00008001);

        do_op("sz11", 0, 2'b11, 0, 32'h0, 0, 0, lat, srd, swr, wd, ma, e);
        check("sz11_lat", lat, 1);
        check("sz11_err", 32'(e), 1);
        check("sz11_strobes", {srd, swr}, 0);

        do_op("sh_mis", 1, 2'b01, 0, 32'h3, 32'h5555, 0, lat, srd, swr, wd, ma, e);
        check("sh_mis_err", {31'h0, e} | {30'h0, srd, swr} << 1, 1);

        // word load with req_valid dropped right after acceptance
        do_op("lw_drop", 0, 2'b10, 0, 32'h8, 0, 1, lat, srd, swr, wd, ma, e);
        check("lw_drop_lat", lat, 3);
        check("lw_drop_rdata", rdata, 32'h1234BEEF);

        do_op("sb", 1, 2'b00, 0, 32'h5, 32'hFFFFFFAB, 0, lat, srd, swr, wd, ma, e);
        check("sb_wdata", wd, 32'h1122AB44);
        check("sb_addr", ma, 1);
        check("sb_err", 32'(e), 0);

        do_op("lb_pos", 0, 2'b00, 0, 32'h4, 0, 0, lat, srd, swr, wd, ma, e);
        check("lb_pos_rdata", rdata, 32'h00000044);

        // reset asserted while a byte store sits in WAIT
        req_write = 1; req_size = 2'b00; req_unsigned = 0; req_addr = 32'h1C;
        req_wdata = 32'h77; req_valid = 1;
        mem[7] = 32'hCAFEBABE;
        @(posedge clk); #1;
        check("rst_mid_read", 32'(mem_read), 1);
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 0;
        #1;
        check("rst_mid_done", 32'(done), 0);
        check("rst_mid_strobes", {30'h0, mem_read, mem_write}, 0);
        check("rst_mid_rdata", rdata, 0);
        check("rst_mid_mem_addr", mem_addr, 0);
        check("rst_mid_mem_wdata", mem_wdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        begin
            int wr_seen = 0;
            repeat (6) begin
                @(posedge clk); #1;
                if (mem_write) wr_seen++;
            end
            check("rst_mid_no_write", wr_seen, 0);
        end
        check("rst_mid_mem", mem[7], 32'hCAFEBABE);
        $display("[TB] reset during sb WAIT: mem[7]=0x%08h", mem[7]);

        do_op("sw_after", 1, 2'b10, 0, 32'h1C, 32'h01020304, 0, lat, srd, swr, wd, ma, e);
        check("sw_after_lat", lat, 2);
        check("sw_after_wdata", wd, 32'h01020304);
        check("sw_after_addr", ma, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: ADDR_WIDTH, 32, byte-address width; DATA_WIDTH, 32, word width (only 32 supported).
REQ-002 clk  in  1  single clock; all state on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  MEM-stage access request; held with stable fields until done.
REQ-005 req_write  in  1  1=store, 0=load.
REQ-006 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend.
REQ-008 req_addr  in  ADDR_WIDTH  byte address.
REQ-009 req_wdata  in  DATA_WIDTH  store data, right-justified.
REQ-010 busy  out  1  pipeline stall request.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  misaligned/illegal flag, valid only with done.
REQ-013 rdata  out  DATA_WIDTH  extended load result.
REQ-014 mem_addr  out  ADDR_WIDTH  word index to data memory ({2'b00, addr[31:2]}).
REQ-015 mem_wdata  out  DATA_WIDTH  word to data memory.
REQ-016 mem_write / mem_read  out  1 each  data-memory write/read strobes.
REQ-017 mem_rdata  in  DATA_WIDTH  data-memory output, registered one cycle after mem_read edge.

Function
REQ-018 FSM states IDLE, READ, WAIT, WRITE, DONE.
REQ-019 Accept only in IDLE with req_valid=1; latch write, size, unsigned, addr, wdata at that edge; ignore input changes until DONE.
REQ-020 Accept-edge transitions: misaligned/illegal -> DONE; word store -> WRITE; load or sub-word store -> READ.
REQ-021 Misaligned: half with addr[0]=1, word with addr[1:0]!=00, any req_size=11.
REQ-022 READ: mem_read=1 -> WAIT; WAIT: mem_rdata valid; load -> extract, register rdata -> DONE; sub-word store -> register merged word -> WRITE.
REQ-023 WRITE: mem_write=1 -> DONE; DONE: done=1 -> IDLE unconditionally.
REQ-024 Latency, cycles from accept cycle T0 to done: misaligned T1, word store T2, load T3, sub-word store T4.
REQ-025 mem_read=1 only in READ; mem_write=1 only in WRITE; never both; mem_addr = latched word index.
REQ-026 Little-endian: byte lane k=addr[1:0] -> bits[8k+7:8k]; half h=addr[1] -> bits[16h+15:16h].
REQ-027 Sub-word store: replace only the addressed lane(s) with req_wdata low bits; other bytes preserved from read word.
REQ-028 Loads: extract lane, sign- or zero-extend per req_unsigned; word ignores req_unsigned.
REQ-029 err=1 with done only for misaligned/illegal; no mem_read/mem_write issued; rdata unchanged.
REQ-030 rdata holds until the next successful load completes; stores do not alter it.
REQ-031 busy = req_valid && state!=DONE (combinational); busy=0 in the DONE cycle.
REQ-032 req_valid dropped mid-operation: operation still completes and done still pulses.
REQ-033 New request is accepted no earlier than the IDLE cycle after DONE.

Reset
REQ-034 rst=1 forces immediately: state IDLE; done, err, busy-state, mem_read, mem_write = 0; rdata, mem_addr, mem_wdata, latched fields = 0.
REQ-035 Reset mid-operation abandons the access; no mem_write is issued for it after reset release.

Verification
REQ-036 sw addr 0x0000_0008 data 0xDEADBEEF -> T1 mem_write=1, mem_addr=2, mem_wdata=0xDEADBEEF; T2 done=1, err=0; no mem_read.
REQ-037 lb addr 0x0000_000B, memory word 0xDEADBEEF -> T1 mem_read, mem_addr=2; T3 done, rdata=0xFFFFFFDE; lbu -> 0x000000DE.
REQ-038 sh addr 0x0000_000A data 0x00001234 over word 0xDEADBEEF -> T3 mem_write, mem_wdata=0x1234BEEF; T4 done.
REQ-039 lh/lhu addr 0x0000_0002 word 0x80017FFF -> rdata 0xFFFF8001 / 0x00008001.
REQ-040 lw addr 0x0000_0006 -> T1 done=1, err=1, no memory strobes, rdata unchanged; req_size=11 same.
REQ-041 rst pulsed in WAIT of sb -> all outputs 0 at once, no mem_write ever; next sw completes normally in 2 cycles.
